// File: rtl/ft_pkg.sv
// Shared types and helpers for the lockstep fault-tolerance checker.
package ft_pkg;

  // Supported lockstep configurations.
  localparam int unsigned NCORES_DMR = 32'd2;
  localparam int unsigned NCORES_TMR = 32'd3;

  // Checker FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECOVER = 2'd1,
    RESET   = 2'd2,
    FATAL   = 2'd3
  } ft_state_e;

  // One register-file writeback as seen from a single core.
  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } commit_t;

  // Two commits match when neither writes, or when the whole tuple is equal.
  // A core that does not write carries don't-care address/data.
  function automatic logic commit_eq(input commit_t a, input commit_t b);
    logic eq_s;
    if (!a.we && !b.we) begin
      eq_s = 1'b1;
    end else begin
      eq_s = (a == b);
    end
    return eq_s;
  endfunction

endpackage

// File: rtl/ft_majority_voter.sv
// Combinational comparator/voter across the lockstepped cores' commits.
module ft_majority_voter
  import ft_pkg::*;
#(
  parameter int unsigned NCORES = 32'd2
) (
  input  commit_t [NCORES-1:0] commit_i,
  output logic                 all_equal_o,
  output logic                 majority_valid_o,
  output logic [NCORES-1:0]    minority_onehot_o
);

  if (NCORES == NCORES_DMR) begin : g_dmr
    // Two cores: either they agree or nobody can be outvoted.
    always_comb begin
      all_equal_o       = commit_eq(commit_i[0], commit_i[1]);
      majority_valid_o  = all_equal_o;
      minority_onehot_o = {NCORES{1'b0}};
    end
  end else if (NCORES == NCORES_TMR) begin : g_tmr
    logic eq01_s;
    logic eq02_s;
    logic eq12_s;

    // Pairwise compare; match is transitive, so a single agreeing pair
    // outvotes the third core.
    always_comb begin
      eq01_s            = commit_eq(commit_i[0], commit_i[1]);
      eq02_s            = commit_eq(commit_i[0], commit_i[2]);
      eq12_s            = commit_eq(commit_i[1], commit_i[2]);
      all_equal_o       = eq01_s & eq02_s;
      majority_valid_o  = eq01_s | eq02_s | eq12_s;
      minority_onehot_o = {eq01_s & ~all_equal_o,
                           eq02_s & ~all_equal_o,
                           eq12_s & ~all_equal_o};
    end
  end else begin : g_bad_ncores
    $error("ft_majority_voter: NCORES must be 2 or 3");
  end

endmodule

// File: rtl/ft_lockstep_checker.sv
// Lockstep comparator for 2 (DMR) or 3 (TMR) cores with checkpointing,
// recovery handshake, recovery timeout and saturating error count.
module ft_lockstep_checker
  import ft_pkg::*;
#(
  parameter int unsigned NCORES     = 32'd2,
  parameter bit          MASK_EN    = 1'b1,
  parameter int unsigned TIMEOUT    = 32'd1024,
  parameter int unsigned RST_CYCLES = 32'd4,
  parameter int unsigned CNT_W      = 32'd8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic [NCORES-1:0]    we_i,
  input  logic [NCORES*5-1:0]  waddr_i,
  input  logic [NCORES*32-1:0] wdata_i,
  input  logic [31:0]          pc_i,
  input  logic                 valid_instr_i,
  input  logic                 done_i,
  output logic                 recover_o,
  output logic                 reset_o,
  output logic                 recovering_o,
  output logic                 mismatch_o,
  output logic [NCORES-1:0]    faulty_core_o,
  output logic [CNT_W-1:0]     err_count_o,
  output logic [31:0]          checkpoint_pc_o,
  output logic                 fatal_o
);

  localparam int unsigned TMR_W = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 32'd1;
  localparam int unsigned RST_W = (RST_CYCLES > 32'd1) ? $clog2(RST_CYCLES) : 32'd1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 32'd1);
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  commit_t [NCORES-1:0] commit_s;
  logic                 all_equal_s;
  logic                 majority_valid_s;
  logic [NCORES-1:0]    minority_s;
  logic                 div_s;
  logic                 trig_s;

  ft_state_e            state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [RST_W-1:0]     rst_cnt_q, rst_cnt_d;
  logic                 recover_q, recover_d;
  logic                 reset_q, reset_d;
  logic                 mismatch_q, mismatch_d;
  logic [NCORES-1:0]    faulty_q, faulty_d;
  logic [CNT_W-1:0]     err_q, err_d;
  logic [31:0]          cp_q, cp_d;
  logic                 fatal_q, fatal_d;

  // Slice the flat writeback buses into one commit tuple per core.
  always_comb begin
    commit_s = '0;
    for (int k = 0; k < int'(NCORES); k++) begin
      commit_s[k].we   = we_i[k];
      commit_s[k].addr = waddr_i[5*k +: 5];
      commit_s[k].data = wdata_i[32*k +: 32];
    end
  end

  ft_majority_voter #(
    .NCORES (NCORES)
  ) u_voter (
    .commit_i          (commit_s),
    .all_equal_o       (all_equal_s),
    .majority_valid_o  (majority_valid_s),
    .minority_onehot_o (minority_s)
  );

  // Divergence is only meaningful while idle and enabled; a single-core
  // TMR fault is masked in place when masking is enabled.
  always_comb begin
    div_s = enable_i & (state_q == IDLE) & ~all_equal_s;
    if ((NCORES == NCORES_TMR) && MASK_EN && majority_valid_s) begin
      trig_s = 1'b0;
    end else begin
      trig_s = div_s;
    end
  end

  // Recovery FSM next state and the timeout/reset-length counters.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    rst_cnt_d = rst_cnt_q;
    case (state_q)
      IDLE: begin
        timer_d   = {TMR_W{1'b0}};
        rst_cnt_d = {RST_W{1'b0}};
        if (trig_s) begin
          state_d = RECOVER;
        end else begin
          state_d = IDLE;
        end
      end
      RECOVER: begin
        rst_cnt_d = {RST_W{1'b0}};
        if (done_i) begin
          state_d = RESET;
        end else if (timer_q == TMR_LAST) begin
          state_d = FATAL;
        end else begin
          timer_d = timer_q + {{(TMR_W-1){1'b0}}, 1'b1};
        end
      end
      RESET: begin
        timer_d = {TMR_W{1'b0}};
        if (rst_cnt_q == RST_LAST) begin
          state_d = IDLE;
        end else begin
          rst_cnt_d = rst_cnt_q + {{(RST_W-1){1'b0}}, 1'b1};
        end
      end
      FATAL: begin
        state_d = FATAL;
      end
      default: begin
        state_d = FATAL;
      end
    endcase
  end

  // Next values of the registered outputs; requests follow the next state.
  always_comb begin
    recover_d  = (state_d == RECOVER);
    reset_d    = (state_d == RESET);
    fatal_d    = fatal_q | (state_d == FATAL);
    mismatch_d = div_s;
    if (div_s) begin
      faulty_d = faulty_q | minority_s;
    end else begin
      faulty_d = faulty_q;
    end
    if (div_s && (err_q != CNT_MAX)) begin
      err_d = err_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      err_d = err_q;
    end
    if (valid_instr_i && (state_q == IDLE) && !div_s) begin
      cp_d = pc_i;
    end else begin
      cp_d = cp_q;
    end
  end

  // State and output registers; everything returns to zero/IDLE on rst_ni.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      timer_q    <= {TMR_W{1'b0}};
      rst_cnt_q  <= {RST_W{1'b0}};
      recover_q  <= 1'b0;
      reset_q    <= 1'b0;
      mismatch_q <= 1'b0;
      faulty_q   <= {NCORES{1'b0}};
      err_q      <= {CNT_W{1'b0}};
      cp_q       <= 32'h0000_0000;
      fatal_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      rst_cnt_q  <= rst_cnt_d;
      recover_q  <= recover_d;
      reset_q    <= reset_d;
      mismatch_q <= mismatch_d;
      faulty_q   <= faulty_d;
      err_q      <= err_d;
      cp_q       <= cp_d;
      fatal_q    <= fatal_d;
    end
  end

  assign recover_o       = recover_q;
  assign recovering_o    = recover_q;
  assign reset_o         = reset_q;
  assign mismatch_o      = mismatch_q;
  assign faulty_core_o   = faulty_q;
  assign err_count_o     = err_q;
  assign checkpoint_pc_o = cp_q;
  assign fatal_o         = fatal_q;

endmodule

// File: tb/tb_ft_lockstep_checker.sv
// Scoreboard bench: a DMR instance (TIMEOUT=16, CNT_W=2) and a TMR masking
// instance share one stimulus bus; each cycle's expected outputs are queued
// by the driver and checked by an independent monitor after the clock edge.
module tb_ft_lockstep_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_d, en_t;
  logic [2:0]  we;
  logic [14:0] waddr;
  logic [95:0] wdata;
  logic [31:0] pc;
  logic        vi, done;

  logic        d_rec, d_rst, d_ring, d_mm, d_fat;
  logic [1:0]  d_fc;
  logic [1:0]  d_ec;
  logic [31:0] d_cp;
  logic        t_rec, t_rst, t_ring, t_mm, t_fat;
  logic [2:0]  t_fc;
  logic [7:0]  t_ec;
  logic [31:0] t_cp;

  always #5 clk = ~clk;

  ft_lockstep_checker #(
    .NCORES(2), .MASK_EN(1'b1), .TIMEOUT(16), .RST_CYCLES(4), .CNT_W(2)
  ) u_dmr (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en_d), .we_i(we[1:0]),
    .waddr_i(waddr[9:0]), .wdata_i(wdata[63:0]), .pc_i(pc),
    .valid_instr_i(vi), .done_i(done), .recover_o(d_rec), .reset_o(d_rst),
    .recovering_o(d_ring), .mismatch_o(d_mm), .faulty_core_o(d_fc),
    .err_count_o(d_ec), .checkpoint_pc_o(d_cp), .fatal_o(d_fat)
  );

  ft_lockstep_checker #(
    .NCORES(3), .MASK_EN(1'b1), .TIMEOUT(1024), .RST_CYCLES(4), .CNT_W(8)
  ) u_tmr (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(en_t), .we_i(we),
    .waddr_i(waddr), .wdata_i(wdata), .pc_i(pc),
    .valid_instr_i(vi), .done_i(done), .recover_o(t_rec), .reset_o(t_rst),
    .recovering_o(t_ring), .mismatch_o(t_mm), .faulty_core_o(t_fc),
    .err_count_o(t_ec), .checkpoint_pc_o(t_cp), .fatal_o(t_fat)
  );

  typedef struct {
    bit          dut;
    logic        mm, rec, rst, fat;
    logic [2:0]  fc;
    logic [7:0]  ec;
    logic [31:0] cp;
    string       tag;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [2:0]  e_fc;
  logic [7:0]  e_ec;
  logic [31:0] e_cp;
  logic [37:0] ok_c, bad_c, z_c, z2_c, a5_c, a6_c;

  function automatic logic [37:0] mk(input logic w, input logic [4:0] a, input logic [31:0] d);
    return {w, a, d};
  endfunction

  task automatic chk(input string tag, input string what, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s %s: got 0x%0h, expected 0x%0h", tag, what, act, req);
    end
  endtask

  // Drive one cycle of stimulus and queue the outputs expected after its edge.
  task automatic cyc(input bit d, input bit r, input bit en,
                     input logic [37:0] c0, input logic [37:0] c1, input logic [37:0] c2,
                     input logic [31:0] p, input logic v, input logic dn,
                     input logic mm, input logic rec, input logic rst, input logic fat,
                     input string tag);
    exp_t e;
    @(negedge clk);
    rst_n = ~r;
    en_d  = en & ~d;
    en_t  = en & d;
    we    = {c2[37], c1[37], c0[37]};
    waddr = {c2[36:32], c1[36:32], c0[36:32]};
    wdata = {c2[31:0], c1[31:0], c0[31:0]};
    pc    = p;
    vi    = v;
    done  = dn;
    e.dut = d; e.mm = mm; e.rec = rec; e.rst = rst; e.fat = fat;
    e.fc  = e_fc; e.ec = e_ec; e.cp = e_cp; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // done handshake, four reset cycles, then back to IDLE; inputs diverge
  // throughout to show they are ignored outside IDLE.
  task automatic finish_rec(input bit d, input string tag);
    cyc(d, 1'b0, 1'b1, ok_c, bad_c, bad_c, 32'hDEAD_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, tag);
    for (int i = 0; i < 3; i++)
      cyc(d, 1'b0, 1'b1, ok_c, bad_c, bad_c, 32'hDEAD_0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, tag);
    cyc(d, 1'b0, 1'b1, ok_c, bad_c, bad_c, 32'hDEAD_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  // Monitor: after every active edge, pop one expectation and compare.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      chk(mon_e.tag, "mismatch_o",      mon_e.dut ? t_mm   : d_mm,   mon_e.mm);
      chk(mon_e.tag, "recover_o",       mon_e.dut ? t_rec  : d_rec,  mon_e.rec);
      chk(mon_e.tag, "recovering_o",    mon_e.dut ? t_ring : d_ring, mon_e.rec);
      chk(mon_e.tag, "reset_o",         mon_e.dut ? t_rst  : d_rst,  mon_e.rst);
      chk(mon_e.tag, "fatal_o",         mon_e.dut ? t_fat  : d_fat,  mon_e.fat);
      chk(mon_e.tag, "faulty_core_o",   mon_e.dut ? t_fc   : {1'b0, d_fc}, mon_e.fc);
      chk(mon_e.tag, "err_count_o",     mon_e.dut ? t_ec   : {6'b0, d_ec}, mon_e.ec);
      chk(mon_e.tag, "checkpoint_pc_o", mon_e.dut ? t_cp   : d_cp,   mon_e.cp);
    end
  end

  initial begin
    rst_n = 1'b0; en_d = 1'b0; en_t = 1'b0; we = 3'b000;
    waddr = 15'd0; wdata = 96'd0; pc = 32'd0; vi = 1'b0; done = 1'b0;
    e_fc = 3'b000; e_ec = 8'd0; e_cp = 32'd0;
    ok_c  = mk(1'b1, 5'd5, 32'hDEAD_BEEF);
    bad_c = mk(1'b1, 5'd5, 32'hDEAD_BEEE);
    z_c   = 38'd0;
    z2_c  = mk(1'b0, 5'd3, 32'h0000_1234);
    a5_c  = mk(1'b1, 5'd5, 32'h1111_2222);
    a6_c  = mk(1'b1, 5'd6, 32'h1111_2222);

    // ---------------- DMR ----------------
    cyc(1'b0, 1'b1, 1'b0, z_c, z_c, z_c, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "dmr_reset");
    e_cp = 32'h80;
    cyc(1'b0, 1'b0, 1'b1, ok_c, ok_c, z_c, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t1_match");
    e_cp = 32'h84;
    cyc(1'b0, 1'b0, 1'b1, z_c, z2_c, z_c, 32'h84, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t1_we0");
    cyc(1'b0, 1'b0, 1'b1, ok_c, ok_c, z_c, 32'h88, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t1_novalid");
    e_ec = 8'd1;
    cyc(1'b0, 1'b0, 1'b1, ok_c, bad_c, z_c, 32'h8C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "t2_div");
    for (int i = 0; i < 2; i++)
      cyc(1'b0, 1'b0, 1'b1, ok_c, bad_c, z_c, 32'h90, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t2_rec");
    finish_rec(1'b0, "t2_reset");
    e_cp = 32'h94;
    cyc(1'b0, 1'b0, 1'b1, ok_c, ok_c, z_c, 32'h94, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t2_resume");
    e_cp = 32'hA0;
    cyc(1'b0, 1'b0, 1'b0, ok_c, bad_c, z_c, 32'hA0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "en_off");

    e_ec = 8'd2;
    cyc(1'b0, 1'b0, 1'b1, ok_c, bad_c, z_c, 32'hA4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "t5_div");
    for (int i = 0; i < 15; i++)
      cyc(1'b0, 1'b0, 1'b1, ok_c, ok_c, z_c, 32'hA8, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t5_wait");
    cyc(1'b0, 1'b0, 1'b1, ok_c, ok_c, z_c, 32'hA8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t5_fatal");
    for (int i = 0; i < 3; i++)
      cyc(1'b0, 1'b0, 1'b1, ok_c, bad_c, z_c, 32'hB0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "t5_stuck");
    e_fc = 3'b000; e_ec = 8'd0; e_cp = 32'd0;
    cyc(1'b0, 1'b1, 1'b0, z_c, z_c, z_c, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t5_rst");

    for (int k = 0; k < 4; k++) begin
      e_ec = (k < 3) ? 8'(k + 1) : 8'd3;
      cyc(1'b0, 1'b0, 1'b1, ok_c, bad_c, z_c, 32'hC0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "t6_div");
      if (k == 0) begin
        for (int i = 0; i < 15; i++)
          cyc(1'b0, 1'b0, 1'b1, ok_c, ok_c, z_c, 32'hC4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t6_to_edge");
      end
      finish_rec(1'b0, "t6_reset");
    end
    e_ec = 8'd3;
    cyc(1'b0, 1'b0, 1'b1, ok_c, bad_c, z_c, 32'hC8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "t6_sat");
    cyc(1'b0, 1'b0, 1'b1, ok_c, bad_c, z_c, 32'hC8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "t6_mid");
    cyc(1'b0, 1'b0, 1'b1, ok_c, bad_c, z_c, 32'hC8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "t6_mid");
    e_fc = 3'b000; e_ec = 8'd0; e_cp = 32'd0;
    cyc(1'b0, 1'b1, 1'b1, ok_c, bad_c, z_c, 32'hC8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "t6_rst");
    cyc(1'b0, 1'b0, 1'b1, ok_c, ok_c, z_c, 32'hCC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t6_idle");

    // ---------------- TMR, masking ----------------
    cyc(1'b1, 1'b1, 1'b0, z_c, z_c, z_c, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "tmr_reset");
    e_fc = 3'b100; e_ec = 8'd1;
    cyc(1'b1, 1'b0, 1'b1, a5_c, a5_c, a6_c, 32'h100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "t3_addr");
    e_cp = 32'h104;
    cyc(1'b1, 1'b0, 1'b1, a5_c, a5_c, a5_c, 32'h104, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t3_clean");
    e_fc = 3'b101; e_ec = 8'd2;
    cyc(1'b1, 1'b0, 1'b1, mk(1'b1, 5'd5, 32'h1111_2223), a5_c, a5_c, 32'h108, 1'b1, 1'b0,
        1'b1, 1'b0, 1'b0, 1'b0, "t3_core0");
    e_fc = 3'b111; e_ec = 8'd3;
    cyc(1'b1, 1'b0, 1'b1, a5_c, mk(1'b0, 5'd5, 32'h1111_2222), a5_c, 32'h108, 1'b0, 1'b0,
        1'b1, 1'b0, 1'b0, 1'b0, "t3_core1we");
    e_cp = 32'h10C;
    cyc(1'b1, 1'b0, 1'b1, z_c, z2_c, mk(1'b0, 5'd7, 32'h5), 32'h10C, 1'b1, 1'b0,
        1'b0, 1'b0, 1'b0, 1'b0, "t3_we0");
    e_ec = 8'd4;
    cyc(1'b1, 1'b0, 1'b1, mk(1'b1, 5'd5, 32'h1), mk(1'b1, 5'd5, 32'h2), mk(1'b1, 5'd5, 32'h3),
        32'h110, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "t4_div");
    cyc(1'b1, 1'b0, 1'b1, a5_c, a5_c, a6_c, 32'h110, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "t4_rec");
    finish_rec(1'b1, "t4_reset");
    e_cp = 32'h114;
    cyc(1'b1, 1'b0, 1'b1, a5_c, a5_c, a5_c, 32'h114, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "t4_resume");

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
